// File: rtl/gesture_power_switch_if.sv
// ----------------------------------------------------------------------------
// gesture_power_switch_if
//   Signal bundle between the gesture power switch and its surroundings
//   (setting stage, key debouncers, mode controller, display).
//
//   Inputs to the switch:
//     en            gesture recognition enable (standby/run modes only)
//     force_off     synchronous request to drop to OFF_IDLE
//     key_l, key_r  debounced key levels, high = pressed
//     gesture_time  gesture window length in seconds
//   Outputs from the switch:
//     power_on      registered hood power state
//     power_toggle  one-cycle pulse on every power_on change
//     armed         a gesture window is open
//     remaining     seconds left in the open window, 0 when not armed
//
//   master : the side that drives the keys/controls (environment, bench)
//   slave  : the gesture power switch itself
// ----------------------------------------------------------------------------
interface gesture_power_switch_if;
    logic       en;
    logic       force_off;
    logic       key_l;
    logic       key_r;
    logic [3:0] gesture_time;
    logic       power_on;
    logic       power_toggle;
    logic       armed;
    logic [3:0] remaining;

    modport master (
        output en,
        output force_off,
        output key_l,
        output key_r,
        output gesture_time,
        input  power_on,
        input  power_toggle,
        input  armed,
        input  remaining
    );

    modport slave (
        input  en,
        input  force_off,
        input  key_l,
        input  key_r,
        input  gesture_time,
        output power_on,
        output power_toggle,
        output armed,
        output remaining
    );
endinterface

// File: rtl/gesture_power_switch.sv
// ----------------------------------------------------------------------------
// gesture_power_switch
//   Turns the hood on and off with two-key gestures.
//     power on : left key press, then right key press within gesture_time s
//     power off: right key press, then left key press within gesture_time s
//   The first press of a gesture opens a window of gesture_time seconds;
//   the window counts down in whole seconds derived from CLK_FREQ.
//
//   Parameters:
//     CLK_FREQ   clk cycles per second (>= 2)
//     CNT_WIDTH  width of the in-second cycle counter (must hold CLK_FREQ-1)
//
//   Ports:
//     clk   system clock
//     rstn  asynchronous active-low reset
//     bus   gesture_power_switch_if.slave (en, force_off, key_l, key_r,
//           gesture_time in; power_on, power_toggle, armed, remaining out)
// ----------------------------------------------------------------------------
module gesture_power_switch #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int CNT_WIDTH = 27
) (
    input  logic                  clk,
    input  logic                  rstn,
    gesture_power_switch_if.slave bus
);

    // Every legal state has even parity, so any single-bit upset lands on an
    // odd-parity code and is caught by state_parity_ok().
    typedef enum logic [2:0] {
        OFF_IDLE  = 3'b000,
        OFF_ARMED = 3'b011,
        ON_IDLE   = 3'b101,
        ON_ARMED  = 3'b110
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(CLK_FREQ - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    function automatic logic state_parity_ok(input state_t s);
        return ~(^s);
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   power_on_r;
    logic                   power_on_nxt_s;
    logic                   power_toggle_r;
    logic                   power_toggle_nxt_s;
    logic                   armed_r;
    logic                   armed_nxt_s;
    logic [3:0]             remaining_r;
    logic [3:0]             remaining_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_nxt_s;
    logic                   key_l_q_r;
    logic                   key_r_q_r;

    logic                   rise_l_s;
    logic                   rise_r_s;
    logic                   tap_l_s;
    logic                   tap_r_s;
    logic                   wrap_s;
    logic                   expire_s;
    logic                   gt_zero_s;
    logic [3:0]             rem_run_s;
    logic [CNT_WIDTH-1:0]   cnt_run_s;

    // Key edge detection; simultaneous rises cancel each other out.
    always_comb begin
        rise_l_s  = bus.key_l & ~key_l_q_r;
        rise_r_s  = bus.key_r & ~key_r_q_r;
        tap_l_s   = rise_l_s & ~rise_r_s;
        tap_r_s   = rise_r_s & ~rise_l_s;
        gt_zero_s = (bus.gesture_time == 4'd0);
    end

    // Window timer: advance the in-second counter, step remaining at wrap.
    always_comb begin
        wrap_s = (cnt_r == CNT_MAX);
        // remaining <= 1 at wrap closes the window; 0 is treated the same so a
        // corrupted count can never hold the window open.
        expire_s = wrap_s && (remaining_r <= 4'd1);
        if (wrap_s) begin
            cnt_run_s = CNT_ZERO;
            rem_run_s = remaining_r - 4'd1;
        end else begin
            cnt_run_s = cnt_r + CNT_ONE;
            rem_run_s = remaining_r;
        end
    end

    // Next-state logic; timer values default to cleared so IDLE holds zeros.
    always_comb begin
        state_nxt_s     = state_r;
        power_on_nxt_s  = power_on_r;
        remaining_nxt_s = 4'd0;
        cnt_nxt_s       = CNT_ZERO;
        if (bus.force_off || !state_parity_ok(state_r)) begin
            state_nxt_s    = OFF_IDLE;
            power_on_nxt_s = 1'b0;
        end else begin
            case (state_r)
                OFF_IDLE: begin
                    power_on_nxt_s = 1'b0;
                    if (bus.en && tap_l_s && !gt_zero_s) begin
                        state_nxt_s     = OFF_ARMED;
                        remaining_nxt_s = bus.gesture_time;
                    end else begin
                        state_nxt_s = OFF_IDLE;
                    end
                end
                OFF_ARMED: begin
                    power_on_nxt_s = 1'b0;
                    if (!bus.en) begin
                        state_nxt_s = OFF_IDLE;
                    end else if (tap_r_s) begin
                        // Completion is checked before expiry so a press on
                        // the timeout cycle still completes the gesture.
                        state_nxt_s    = ON_IDLE;
                        power_on_nxt_s = 1'b1;
                    end else if (tap_l_s) begin
                        if (gt_zero_s) begin
                            state_nxt_s = OFF_IDLE;
                        end else begin
                            state_nxt_s     = OFF_ARMED;
                            remaining_nxt_s = bus.gesture_time;
                        end
                    end else if (expire_s) begin
                        state_nxt_s = OFF_IDLE;
                    end else begin
                        state_nxt_s     = OFF_ARMED;
                        remaining_nxt_s = rem_run_s;
                        cnt_nxt_s       = cnt_run_s;
                    end
                end
                ON_IDLE: begin
                    power_on_nxt_s = 1'b1;
                    if (bus.en && tap_r_s && !gt_zero_s) begin
                        state_nxt_s     = ON_ARMED;
                        remaining_nxt_s = bus.gesture_time;
                    end else begin
                        state_nxt_s = ON_IDLE;
                    end
                end
                ON_ARMED: begin
                    power_on_nxt_s = 1'b1;
                    if (!bus.en) begin
                        state_nxt_s = ON_IDLE;
                    end else if (tap_l_s) begin
                        state_nxt_s    = OFF_IDLE;
                        power_on_nxt_s = 1'b0;
                    end else if (tap_r_s) begin
                        if (gt_zero_s) begin
                            state_nxt_s = ON_IDLE;
                        end else begin
                            state_nxt_s     = ON_ARMED;
                            remaining_nxt_s = bus.gesture_time;
                        end
                    end else if (expire_s) begin
                        state_nxt_s = ON_IDLE;
                    end else begin
                        state_nxt_s     = ON_ARMED;
                        remaining_nxt_s = rem_run_s;
                        cnt_nxt_s       = cnt_run_s;
                    end
                end
                default: begin
                    state_nxt_s    = OFF_IDLE;
                    power_on_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Output logic: decode armed and the toggle pulse from the next state.
    always_comb begin
        case (state_nxt_s)
            OFF_ARMED: armed_nxt_s = 1'b1;
            ON_ARMED:  armed_nxt_s = 1'b1;
            OFF_IDLE:  armed_nxt_s = 1'b0;
            ON_IDLE:   armed_nxt_s = 1'b0;
            default:   armed_nxt_s = 1'b0;
        endcase
        power_toggle_nxt_s = power_on_nxt_s ^ power_on_r;
    end

    // State, timer, output and key-history registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= OFF_IDLE;
            power_on_r     <= 1'b0;
            power_toggle_r <= 1'b0;
            armed_r        <= 1'b0;
            remaining_r    <= 4'd0;
            cnt_r          <= CNT_ZERO;
            key_l_q_r      <= 1'b0;
            key_r_q_r      <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            power_on_r     <= power_on_nxt_s;
            power_toggle_r <= power_toggle_nxt_s;
            armed_r        <= armed_nxt_s;
            remaining_r    <= remaining_nxt_s;
            cnt_r          <= cnt_nxt_s;
            // History keeps tracking while disabled so re-enable sees no
            // stale edge.
            key_l_q_r      <= bus.key_l;
            key_r_q_r      <= bus.key_r;
        end
    end

    assign bus.power_on     = power_on_r;
    assign bus.power_toggle = power_toggle_r;
    assign bus.armed        = armed_r;
    assign bus.remaining    = remaining_r;

endmodule

// File: tb/tb_gesture_power_switch.sv
// ----------------------------------------------------------------------------
// tb_gesture_power_switch
//   Directed bench for gesture_power_switch with CLK_FREQ=10 (1 s = 10 clk).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_gesture_power_switch;

    logic clk;
    logic rstn;
    int   n_total;
    int   n_bad;

    gesture_power_switch_if gp_if ();

    gesture_power_switch #(
        .CLK_FREQ  (10),
        .CNT_WIDTH (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (gp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic p, input logic t,
                            input logic a, input logic [3:0] r);
        chk({tag, ".power_on"},     32'(gp_if.power_on),     32'(p));
        chk({tag, ".power_toggle"}, 32'(gp_if.power_toggle), 32'(t));
        chk({tag, ".armed"},        32'(gp_if.armed),        32'(a));
        chk({tag, ".remaining"},    32'(gp_if.remaining),    32'(r));
    endtask

    initial begin
        n_total            = 0;
        n_bad              = 0;
        rstn               = 1'b0;
        gp_if.en           = 1'b1;
        gp_if.force_off    = 1'b0;
        gp_if.key_l        = 1'b0;
        gp_if.key_r        = 1'b0;
        gp_if.gesture_time = 4'd3;

        tick_n(2);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        rstn = 1'b1;
        tick_n(1);
        chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 4'd0);

        // Power-on gesture: left, then right 15 cycles later.
        gp_if.key_l = 1'b1;
        tick_n(1);
        chk_outs("on_arm", 1'b0, 1'b0, 1'b1, 4'd3);
        gp_if.key_l = 1'b0;
        tick_n(9);
        chk("on_rem3", 32'(gp_if.remaining), 32'd3);
        tick_n(1);
        chk("on_rem2", 32'(gp_if.remaining), 32'd2);
        tick_n(4);
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("on_done", 1'b1, 1'b1, 1'b0, 4'd0);
        gp_if.key_r = 1'b0;
        tick_n(1);
        chk_outs("on_pulse_end", 1'b1, 1'b0, 1'b0, 4'd0);

        // Window timeout while powered on.
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("to_arm", 1'b1, 1'b0, 1'b1, 4'd3);
        gp_if.key_r = 1'b0;
        tick_n(9);
        chk("to_rem3", 32'(gp_if.remaining), 32'd3);
        tick_n(1);
        chk("to_rem2", 32'(gp_if.remaining), 32'd2);
        tick_n(9);
        chk("to_rem2b", 32'(gp_if.remaining), 32'd2);
        tick_n(1);
        chk("to_rem1", 32'(gp_if.remaining), 32'd1);
        tick_n(9);
        chk_outs("to_c29", 1'b1, 1'b0, 1'b1, 4'd1);
        tick_n(1);
        chk_outs("to_c30", 1'b1, 1'b0, 1'b0, 4'd0);

        // force_off from ON: toggle pulses.
        gp_if.force_off = 1'b1;
        tick_n(1);
        chk_outs("fo_on", 1'b0, 1'b1, 1'b0, 4'd0);
        gp_if.force_off = 1'b0;
        tick_n(1);
        chk_outs("fo_on_after", 1'b0, 1'b0, 1'b0, 4'd0);

        // Completing press on the exact timeout cycle wins.
        gp_if.key_l = 1'b1;
        tick_n(1);
        chk_outs("race_arm", 1'b0, 1'b0, 1'b1, 4'd3);
        gp_if.key_l = 1'b0;
        tick_n(29);
        chk_outs("race_c29", 1'b0, 1'b0, 1'b1, 4'd1);
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("race_done", 1'b1, 1'b1, 1'b0, 4'd0);
        gp_if.key_r = 1'b0;
        tick_n(1);

        // Power-off gesture: right, then left.
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("off_arm", 1'b1, 1'b0, 1'b1, 4'd3);
        gp_if.key_r = 1'b0;
        tick_n(2);
        gp_if.key_l = 1'b1;
        tick_n(1);
        chk_outs("off_done", 1'b0, 1'b1, 1'b0, 4'd0);
        gp_if.key_l = 1'b0;
        tick_n(1);

        // gesture_time = 0 never arms.
        gp_if.gesture_time = 4'd0;
        gp_if.key_l = 1'b1;
        tick_n(1);
        chk_outs("gt0", 1'b0, 1'b0, 1'b0, 4'd0);
        gp_if.key_l = 1'b0;
        tick_n(1);
        gp_if.gesture_time = 4'd3;

        // Simultaneous rises are ignored.
        gp_if.key_l = 1'b1;
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("both", 1'b0, 1'b0, 1'b0, 4'd0);
        gp_if.key_l = 1'b0;
        gp_if.key_r = 1'b0;
        tick_n(1);

        // Held key arms once; a re-arm each cycle would pin remaining at 3.
        gp_if.key_l = 1'b1;
        tick_n(1);
        chk_outs("hold_arm", 1'b0, 1'b0, 1'b1, 4'd3);
        tick_n(10);
        chk_outs("hold_rem2", 1'b0, 1'b0, 1'b1, 4'd2);

        // force_off while armed with remaining=2, power already off.
        gp_if.force_off = 1'b1;
        tick_n(1);
        chk_outs("fo_armed", 1'b0, 1'b0, 1'b0, 4'd0);
        gp_if.force_off = 1'b0;
        gp_if.key_l = 1'b0;
        tick_n(1);

        // gesture_time change mid-window does not reload remaining.
        gp_if.key_l = 1'b1;
        tick_n(1);
        chk("gtchg_arm", 32'(gp_if.remaining), 32'd3);
        gp_if.key_l = 1'b0;
        gp_if.gesture_time = 4'd9;
        tick_n(1);
        chk("gtchg_rem3", 32'(gp_if.remaining), 32'd3);
        tick_n(9);
        chk("gtchg_rem2", 32'(gp_if.remaining), 32'd2);

        // Dropping en closes the window next edge.
        gp_if.en = 1'b0;
        tick_n(1);
        chk_outs("en_drop", 1'b0, 1'b0, 1'b0, 4'd0);
        gp_if.en = 1'b1;
        gp_if.gesture_time = 4'd3;
        tick_n(1);

        // Power on, then check en=0 ignores rises and re-enable has no stale edge.
        gp_if.key_l = 1'b1;
        tick_n(1);
        gp_if.key_l = 1'b0;
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("on2", 1'b1, 1'b1, 1'b0, 4'd0);
        gp_if.key_r = 1'b0;
        tick_n(1);
        gp_if.en = 1'b0;
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("dis_rise", 1'b1, 1'b0, 1'b0, 4'd0);
        gp_if.en = 1'b1;
        tick_n(1);
        chk_outs("reen_nostale", 1'b1, 1'b0, 1'b0, 4'd0);
        gp_if.key_r = 1'b0;
        tick_n(1);

        // Asynchronous reset mid-window while powered on.
        gp_if.key_r = 1'b1;
        tick_n(1);
        chk_outs("rst_arm", 1'b1, 1'b0, 1'b1, 4'd3);
        gp_if.key_r = 1'b0;
        tick_n(3);
        #2;
        rstn = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 4'd0);
        tick_n(1);
        rstn = 1'b1;
        tick_n(1);
        chk_outs("rst_release", 1'b0, 1'b0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/gesture_power_switch.md
Name: gesture_power_switch

Overview:
- Consumes gesture_time (seconds, 4-bit) from the setting-mode stage and turns the hood on/off using two-key gestures.
- Power-on gesture: a left-key press then a right-key press within gesture_time seconds. Power-off gesture is the reverse order.
- Drives power_on to the mode controller and exposes the armed window and countdown for display.

Parameters:
- CLK_FREQ, 100_000_000, clk cycles per second; sets the 1 s tick period. Minimum 2.
- CNT_WIDTH, 27, width of the cycle counter; must hold CLK_FREQ-1.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- en  input  1  gesture recognition enable; high only in the standby/run modes
- force_off  input  1  synchronous request to go OFF_IDLE (e.g. self-clean end, fault)
- key_l  input  1  debounced left key level, high = pressed
- key_r  input  1  debounced right key level, high = pressed
- gesture_time  input  4  window length in seconds, from setting stage
- power_on  output  1  registered hood power state
- power_toggle  output  1  one-cycle pulse on every power_on change
- armed  output  1  high while a gesture window is open
- remaining  output  4  seconds left in the open window; 0 when not armed

Behaviour:
- Reset: state=OFF_IDLE, power_on=0, power_toggle=0, armed=0, remaining=0, cycle counter=0, key_l_q=0, key_r_q=0.
- Edge detect: key_x_q is the registered previous level. rise_x = key_x & ~key_x_q. A key held through reset release produces one rise on the first clock.
- Both rise_l and rise_r in the same cycle: ignored, no state change.
- States and transitions (evaluated each clk):
  - OFF_IDLE: rise_l and gesture_time!=0 -> OFF_ARMED. On entry, latch remaining=gesture_time and clear the cycle counter.
  - OFF_ARMED:
    - rise_r -> ON_IDLE, power_on=1, power_toggle=1.
    - rise_l -> restart the window: reload remaining from the current gesture_time, clear the counter. If gesture_time=0 -> OFF_IDLE instead.
    - timeout -> OFF_IDLE.
  - ON_IDLE: rise_r and gesture_time!=0 -> ON_ARMED, with the same latch as above.
  - ON_ARMED:
    - rise_l -> OFF_IDLE, power_on=0, power_toggle=1.
    - rise_r -> restart the window.
    - timeout -> ON_IDLE.
- Window timing:
  - The cycle counter runs only in ARMED states, counting 0..CLK_FREQ-1 and wrapping.
  - At wrap, remaining decrements. When remaining is 1 at wrap: timeout, remaining=0, armed state is left.
  - Window length = gesture_time*CLK_FREQ cycles after the arming edge.
  - A completing rise in the same cycle as the timeout wins (the gesture completes).
- gesture_time is sampled only on arm/restart. Changes mid-window do not affect remaining.
- Latency: power_on changes on the clk edge that first samples the completing key high. power_toggle is high for that following cycle only.
- en=0:
  - ARMED states fall back to the matching IDLE on the next edge.
  - Rises are ignored and power_on is held.
  - Edge registers keep tracking, so no stale rise appears on re-enable.
- force_off (highest priority after reset): next state OFF_IDLE, power_on=0, armed=0, remaining=0. power_toggle pulses only if power_on was 1.
- armed = state is OFF_ARMED or ON_ARMED (registered). remaining is forced to 0 in IDLE states.
- Unreachable state encodings recover to OFF_IDLE with power_on=0.

Test Plan:
- Sim with CLK_FREQ=10, gesture_time=3:
  - Step: rise key_l, then rise key_r 15 cycles later.
  - Expect: power_on=1 and a single power_toggle pulse; remaining reads 3, 2 before completion.
- Power_on=1, gesture_time=3:
  - Step: rise key_r, then no key for 30 cycles.
  - Expect: remaining steps 3->2->1->0, armed drops at cycle 30, power_on stays 1.
- Completion on timeout cycle:
  - Step: rise key_l, then rise key_r exactly on the cycle the timeout fires.
  - Expect: power_on=1.
- Invalid and edge inputs:
  - Step: gesture_time=0, press key_l. Expect: no arm.
  - Step: key_l and key_r rise together. Expect: no arm.
  - Step: key_l held high continuously. Expect: only one arm.
- Reset and force_off:
  - Step: armed with remaining=2, pulse force_off. Expect: OFF_IDLE, remaining=0.
  - Step: power_on=1, assert rstn low asynchronously mid-window. Expect: all outputs 0 immediately.
- Mid-window changes:
  - Step: in OFF_ARMED, change gesture_time 3->9. Expect: remaining continues from 3.
  - Step: drop en. Expect: armed=0 next cycle, power_on unchanged.
